// File: rtl/ide_pkg.sv
// Shared types and constants for the IDE PIO engine: cycle states, address
// decode bit positions and the timing counter width helper.
package ide_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_REC = 3'd1,
      SETUP    = 3'd2,
      STROBE   = 3'd3,
      HOLD     = 3'd4
   } ide_state_t;

   localparam int IDE_REGION_BIT = 16;
   localparam int CS_SEL_BIT     = 11;
   localparam int CH_SEL_LSB     = 12;

   // One spare bit beyond the largest timing value keeps every load in range.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      m = (b > m) ? b : m;
      m = (c > m) ? c : m;
      m = (d > m) ? d : m;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/ide_as_sync.sv
// Two-flop synchroniser bringing the Zorro address strobe into the CLK domain.
// Resets to the deasserted (high) level.
module ide_as_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_as_n,
   output logic o_as_s
);

   logic r_meta;
   logic r_sync;

   // Metastability filter chain for AS_n
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_as_n;
         r_sync <= r_meta;
      end
   end

   assign o_as_s = r_sync;

endmodule

// File: rtl/ide_pio_engine.sv
// Multi-channel IDE PIO cycle engine with programmable setup/strobe/recovery
// timing, plus the boot ROM enable / bank register.
module ide_pio_engine
   import ide_pkg::*;
#(
   parameter int CHANNELS     = 2,
   parameter int SETUP_CYC    = 1,
   parameter int ACTIVE_SLOW  = 4,
   parameter int ACTIVE_FAST  = 2,
   parameter int RECOVERY_CYC = 2
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [23:1]             i_addr,
   input  logic                    i_as_n,
   input  logic                    i_uds_n,
   input  logic                    i_lds_n,
   input  logic                    i_rw,
   input  logic [3:0]              i_din,
   input  logic                    i_ide_access,
   input  logic                    i_ide_enable,
   output logic                    o_dtack,
   output logic                    o_ior_n,
   output logic                    o_iow_n,
   output logic [2*CHANNELS-1:0]   o_ide_cs_n,
   output logic                    o_ide_romen,
   output logic [1:0]              o_rom_bank,
   output logic                    o_fast_mode
);

   localparam int CSW   = 2 * CHANNELS;
   localparam int CNT_W = cnt_width(SETUP_CYC, ACTIVE_SLOW, ACTIVE_FAST, RECOVERY_CYC);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] SLOW_LD  = CNT_W'(ACTIVE_SLOW - 1);
   localparam logic [CNT_W-1:0] FAST_LD  = CNT_W'(ACTIVE_FAST - 1);
   localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(RECOVERY_CYC);

   // Chip-select pattern for selector {ch, k}; a nonexistent channel keeps all high.
   function automatic logic [CSW-1:0] cs_n_of(input logic [2:0] sel, input logic ok);
      return ok ? ~(CSW'(1'b1) << sel) : {CSW{1'b1}};
   endfunction

   logic       w_as_s;
   logic       w_start;
   logic [1:0] w_ch;
   logic [2:0] w_sel;
   logic       w_ch_ok;
   logic       w_unused;

   ide_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_rec_cnt;
   logic [2:0]       r_sel;
   logic             r_ch_ok;
   logic             r_rw;
   logic             r_fast_lat;
   logic             r_ide;
   logic             r_dtack;
   logic             r_ior_n;
   logic             r_iow_n;
   logic [CSW-1:0]   r_cs_n;
   logic             r_romen;
   logic [1:0]       r_bank;
   logic             r_fast;

   ide_as_sync u_as_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_reset_n),
      .i_as_n  (i_as_n),
      .o_as_s  (w_as_s)
   );

   assign w_start  = i_ide_access & i_ide_enable & ~w_as_s & (~i_uds_n | ~i_lds_n);
   assign w_ch     = i_addr[CH_SEL_LSB+1:CH_SEL_LSB];
   assign w_sel    = {w_ch, i_addr[CS_SEL_BIT]};
   assign w_ch_ok  = ({1'b0, w_ch} < 3'(CHANNELS));
   assign w_unused = ^{i_addr[23:17], i_addr[15:14], i_addr[10:1]};

   // PIO cycle sequencer, shared recovery timer and ROM control register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_rec_cnt  <= '0;
         r_sel      <= 3'd0;
         r_ch_ok    <= 1'b0;
         r_rw       <= 1'b0;
         r_fast_lat <= 1'b0;
         r_ide      <= 1'b0;
         r_dtack    <= 1'b0;
         r_ior_n    <= 1'b1;
         r_iow_n    <= 1'b1;
         r_cs_n     <= {CSW{1'b1}};
         r_romen    <= 1'b1;
         r_bank     <= 2'b00;
         r_fast     <= 1'b0;
      end else begin
         // Later loads in the case below take precedence over this countdown.
         if (r_rec_cnt != '0) begin
            r_rec_cnt <= r_rec_cnt - CNT_W'(1'b1);
         end
         case (r_state)
            IDLE: begin
               if (w_start && i_addr[IDE_REGION_BIT]) begin
                  r_sel      <= w_sel;
                  r_ch_ok    <= w_ch_ok;
                  r_rw       <= i_rw;
                  r_fast_lat <= r_fast;
                  r_ide      <= 1'b1;
                  if (r_rec_cnt != '0) begin
                     r_state <= WAIT_REC;
                  end else begin
                     r_state <= SETUP;
                     r_cs_n  <= cs_n_of(w_sel, w_ch_ok);
                     r_cnt   <= SETUP_LD;
                  end
               end else if (w_start && !i_rw) begin
                  r_bank  <= i_din[3:2];
                  r_fast  <= i_din[1];
                  r_romen <= ~i_din[0];
                  r_ide   <= 1'b0;
                  r_dtack <= 1'b1;
                  r_state <= HOLD;
               end else if (w_start && r_romen) begin
                  r_ide   <= 1'b0;
                  r_dtack <= 1'b1;
                  r_state <= HOLD;
               end
            end
            WAIT_REC: begin
               if (w_as_s) begin
                  r_state <= IDLE;
               end else if (r_rec_cnt == '0) begin
                  r_state <= SETUP;
                  r_cs_n  <= cs_n_of(r_sel, r_ch_ok);
                  r_cnt   <= SETUP_LD;
               end
            end
            SETUP: begin
               if (w_as_s) begin
                  r_cs_n    <= {CSW{1'b1}};
                  r_rec_cnt <= REC_LD;
                  r_state   <= IDLE;
               end else if (r_cnt == '0) begin
                  r_ior_n <= ~(r_ch_ok & r_rw);
                  r_iow_n <= ~(r_ch_ok & ~r_rw);
                  r_cnt   <= r_fast_lat ? FAST_LD : SLOW_LD;
                  r_state <= STROBE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1'b1);
               end
            end
            STROBE: begin
               if (w_as_s) begin
                  r_ior_n   <= 1'b1;
                  r_iow_n   <= 1'b1;
                  r_cs_n    <= {CSW{1'b1}};
                  r_rec_cnt <= REC_LD;
                  r_state   <= IDLE;
               end else if (r_cnt == '0) begin
                  r_ior_n <= 1'b1;
                  r_iow_n <= 1'b1;
                  r_dtack <= 1'b1;
                  r_state <= HOLD;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1'b1);
               end
            end
            HOLD: begin
               if (w_as_s) begin
                  r_cs_n  <= {CSW{1'b1}};
                  r_dtack <= 1'b0;
                  if (r_ide) begin
                     r_rec_cnt <= REC_LD;
                  end
                  r_state <= IDLE;
               end
            end
            default: begin
               r_ior_n <= 1'b1;
               r_iow_n <= 1'b1;
               r_cs_n  <= {CSW{1'b1}};
               r_dtack <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_dtack     = r_dtack;
   assign o_ior_n     = r_ior_n;
   assign o_iow_n     = r_iow_n;
   assign o_ide_cs_n  = r_cs_n;
   assign o_ide_romen = r_romen;
   assign o_rom_bank  = r_bank;
   assign o_fast_mode = r_fast;

endmodule

// File: tb/tb_ide_pio_engine.sv
// Scoreboard bench for ide_pio_engine: stimulus queues each expected output change
// with its cycle; a monitor compares every observed output change against it.
module tb_ide_pio_engine;

   typedef struct {
      int          cyc;
      logic [10:0] val;
      string       nm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [23:1] addr = '0;
   logic        as_n = 1'b1;
   logic        uds_n = 1'b1;
   logic        lds_n = 1'b1;
   logic        rw = 1'b1;
   logic [3:0]  din = 4'h0;
   logic        ide_access = 1'b1;
   logic        ide_enable = 1'b1;
   logic        dtack;
   logic        ior_n;
   logic        iow_n;
   logic [3:0]  cs_n;
   logic        romen;
   logic [1:0]  bank;
   logic        fast;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   c0;

   logic       m_romen = 1'b1;
   logic [1:0] m_bank = 2'b00;
   logic       m_fast = 1'b0;

   ide_pio_engine dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_addr       (addr),
      .i_as_n       (as_n),
      .i_uds_n      (uds_n),
      .i_lds_n      (lds_n),
      .i_rw         (rw),
      .i_din        (din),
      .i_ide_access (ide_access),
      .i_ide_enable (ide_enable),
      .o_dtack      (dtack),
      .o_ior_n      (ior_n),
      .o_iow_n      (iow_n),
      .o_ide_cs_n   (cs_n),
      .o_ide_romen  (romen),
      .o_rom_bank   (bank),
      .o_fast_mode  (fast)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [10:0] mk(input logic dt, input logic ior, input logic iow,
                                      input logic [3:0] cs);
      return {m_romen, m_bank, m_fast, dt, ior, iow, cs};
   endfunction

   function automatic logic [23:1] a(input logic ide, input logic [1:0] ch, input logic k);
      logic [23:1] x;
      x = '0;
      x[16] = ide;
      x[13:12] = ch;
      x[11] = k;
      return x;
   endfunction

   task automatic ev(input int at, input logic [10:0] v, input string nm);
      exp_t e;
      e.cyc = at;
      e.val = v;
      e.nm  = nm;
      sb.push_back(e);
   endtask

   task automatic bus(input logic [23:1] ad, input logic rw_i, input logic [3:0] d,
                      input int lo, input int hi);
      addr = ad;
      rw = rw_i;
      din = d;
      as_n = 1'b0;
      uds_n = 1'b0;
      lds_n = 1'b0;
      repeat (lo) @(negedge clk);
      as_n = 1'b1;
      uds_n = 1'b1;
      lds_n = 1'b1;
      repeat (hi) @(negedge clk);
   endtask

   task automatic read_ch0_cs0(input string tag);
      @(negedge clk);
      c0 = cyc;
      ev(c0 + 3,  mk(1'b0, 1'b1, 1'b1, 4'hE), {tag, "_cs_low"});
      ev(c0 + 4,  mk(1'b0, 1'b0, 1'b1, 4'hE), {tag, "_ior_low"});
      ev(c0 + 8,  mk(1'b1, 1'b1, 1'b1, 4'hE), {tag, "_ior_high_dtack"});
      ev(c0 + 11, mk(1'b0, 1'b1, 1'b1, 4'hF), {tag, "_release"});
      bus(a(1'b1, 2'd0, 1'b0), 1'b1, 4'h0, 8, 6);
   endtask

   task automatic reg_write(input logic [3:0] d, input string tag);
      @(negedge clk);
      c0 = cyc;
      m_bank  = d[3:2];
      m_fast  = d[1];
      m_romen = ~d[0];
      ev(c0 + 3, mk(1'b1, 1'b1, 1'b1, 4'hF), {tag, "_dtack"});
      ev(c0 + 7, mk(1'b0, 1'b1, 1'b1, 4'hF), {tag, "_end"});
      bus(a(1'b0, 2'd0, 1'b0), 1'b0, d, 4, 4);
   endtask

   // Monitor: every change of the observed outputs consumes one expectation
   initial begin
      logic [10:0] prev;
      logic [10:0] cur;
      exp_t        e;
      prev = 'x;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         cur = {romen, bank, fast, dtack, ior_n, iow_n, cs_n};
         if (cur !== prev) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_change: cycle %0d value %b, required no change", cyc, cur);
            end else begin
               e = sb.pop_front();
               if (cur !== e.val || (e.cyc >= 0 && e.cyc != cyc)) begin
                  n_bad++;
                  $display("FAIL %s: cycle %0d value %b, required cycle %0d value %b",
                           e.nm, cyc, cur, e.cyc, e.val);
               end
            end
            prev = cur;
         end
      end
   end

   // Directed stimulus
   initial begin
      exp_t e;
      ev(-1, mk(1'b0, 1'b1, 1'b1, 4'hF), "reset_state");
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      read_ch0_cs0("rd0");

      reg_write(4'b1010, "wr1010");
      reg_write(4'b0011, "wr0011");

      // Fast-mode IDE write, ch1 CS0
      @(negedge clk);
      c0 = cyc;
      ev(c0 + 3, mk(1'b0, 1'b1, 1'b1, 4'hB), "fastwr_cs_low");
      ev(c0 + 4, mk(1'b0, 1'b1, 1'b0, 4'hB), "fastwr_iow_low");
      ev(c0 + 6, mk(1'b1, 1'b1, 1'b1, 4'hB), "fastwr_iow_high_dtack");
      ev(c0 + 9, mk(1'b0, 1'b1, 1'b1, 4'hF), "fastwr_release");
      bus(a(1'b1, 2'd1, 1'b0), 1'b0, 4'h0, 6, 6);

      reg_write(4'b0000, "wr0000");

      // ROM read: DTACK only
      @(negedge clk);
      c0 = cyc;
      ev(c0 + 3, mk(1'b1, 1'b1, 1'b1, 4'hF), "romrd_dtack");
      ev(c0 + 7, mk(1'b0, 1'b1, 1'b1, 4'hF), "romrd_end");
      bus(a(1'b0, 2'd0, 1'b0), 1'b1, 4'h0, 4, 4);

      // Card disabled: nothing may move
      @(negedge clk);
      ide_enable = 1'b0;
      bus(a(1'b1, 2'd0, 1'b0), 1'b1, 4'h0, 8, 6);
      ide_enable = 1'b1;

      // Back-to-back ch1 CS1: second access waits out recovery
      @(negedge clk);
      c0 = cyc;
      ev(c0 + 3,  mk(1'b0, 1'b1, 1'b1, 4'h7), "b2b_cs_low_1");
      ev(c0 + 4,  mk(1'b0, 1'b0, 1'b1, 4'h7), "b2b_ior_low_1");
      ev(c0 + 8,  mk(1'b1, 1'b1, 1'b1, 4'h7), "b2b_dtack_1");
      ev(c0 + 11, mk(1'b0, 1'b1, 1'b1, 4'hF), "b2b_release_1");
      ev(c0 + 14, mk(1'b0, 1'b1, 1'b1, 4'h7), "b2b_cs_low_2");
      ev(c0 + 15, mk(1'b0, 1'b0, 1'b1, 4'h7), "b2b_ior_low_2");
      ev(c0 + 19, mk(1'b1, 1'b1, 1'b1, 4'h7), "b2b_dtack_2");
      ev(c0 + 20, mk(1'b0, 1'b1, 1'b1, 4'hF), "b2b_release_2");
      bus(a(1'b1, 2'd1, 1'b1), 1'b1, 4'h0, 8, 1);
      bus(a(1'b1, 2'd1, 1'b1), 1'b1, 4'h0, 8, 8);

      // Nonexistent channel 3: timing runs, only DTACK moves
      @(negedge clk);
      c0 = cyc;
      ev(c0 + 8,  mk(1'b1, 1'b1, 1'b1, 4'hF), "ch3_dtack");
      ev(c0 + 11, mk(1'b0, 1'b1, 1'b1, 4'hF), "ch3_end");
      bus(a(1'b1, 2'd3, 1'b0), 1'b1, 4'h0, 8, 6);

      // Abort mid-strobe, then an immediate retry that must wait for recovery
      @(negedge clk);
      c0 = cyc;
      ev(c0 + 3,  mk(1'b0, 1'b1, 1'b1, 4'hE), "abort_cs_low");
      ev(c0 + 4,  mk(1'b0, 1'b0, 1'b1, 4'hE), "abort_ior_low");
      ev(c0 + 7,  mk(1'b0, 1'b1, 1'b1, 4'hF), "abort_release_no_dtack");
      ev(c0 + 10, mk(1'b0, 1'b1, 1'b1, 4'hE), "retry_cs_low");
      ev(c0 + 11, mk(1'b0, 1'b0, 1'b1, 4'hE), "retry_ior_low");
      ev(c0 + 15, mk(1'b1, 1'b1, 1'b1, 4'hE), "retry_dtack");
      ev(c0 + 16, mk(1'b0, 1'b1, 1'b1, 4'hF), "retry_release");
      bus(a(1'b1, 2'd0, 1'b0), 1'b1, 4'h0, 4, 1);
      bus(a(1'b1, 2'd0, 1'b0), 1'b1, 4'h0, 8, 8);

      reg_write(4'b1000, "wr1000");

      // Asynchronous reset in the middle of a read strobe
      @(negedge clk);
      c0 = cyc;
      ev(c0 + 3, mk(1'b0, 1'b1, 1'b1, 4'hE), "rst_cs_low");
      ev(c0 + 4, mk(1'b0, 1'b0, 1'b1, 4'hE), "rst_ior_low");
      m_bank  = 2'b00;
      m_fast  = 1'b0;
      m_romen = 1'b1;
      ev(c0 + 5, mk(1'b0, 1'b1, 1'b1, 4'hF), "rst_async_clear");
      addr = a(1'b1, 2'd0, 1'b0);
      rw = 1'b1;
      as_n = 1'b0;
      uds_n = 1'b0;
      lds_n = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      as_n = 1'b1;
      uds_n = 1'b1;
      lds_n = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      read_ch0_cs0("post_rst");

      repeat (6) @(negedge clk);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missing_%s: not seen, required at cycle %0d value %b", e.nm, e.cyc, e.val);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
